// File: rtl/adc_reader_pkg.sv
// adc_reader_pkg: shared types and default constants for the serial ADC reader.
//   state_e         - reader FSM states
//   DEF_*           - default CLK_DIV / CONV_CYCLES / DATA_WIDTH
//   cnt_w()         - counter width able to hold n-1 (at least one bit)
package adc_reader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SHIFT   = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam int DEF_CLK_DIV     = 2;
  localparam int DEF_CONV_CYCLES = 10;
  localparam int DEF_DATA_WIDTH  = 16;

  // Width of a counter that must reach n-1 without wrapping.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_sck_gen.sv
// adc_sck_gen: serial clock generator for the ADC read phase.
//   clk, reset  - system clock, async active-high reset
//   run         - high while the reader is shifting; low clears all counters
//   sck         - registered serial clock, CLK_DIV cycles low then CLK_DIV high
//   sample      - high in the cycle whose closing edge raises sck
//   last_bit    - high in the final cycle of the last high phase
module adc_sck_gen
  import adc_reader_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic sck,
  output logic sample,
  output logic last_bit
);

  localparam int DIV_W = cnt_w(CLK_DIV);
  localparam int BIT_W = cnt_w(DATA_WIDTH);

  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             sck_q, sck_d;
  logic             div_end;
  logic             bit_last;

  assign div_end  = (div_q == DIV_W'(CLK_DIV - 1));
  assign bit_last = (bit_q == BIT_W'(DATA_WIDTH - 1));

  always_comb begin
    div_d = div_q;
    bit_d = bit_q;
    sck_d = sck_q;
    if (!run) begin
      div_d = '0;
      bit_d = '0;
      sck_d = 1'b0;
    end else if (div_end) begin
      div_d = '0;
      sck_d = ~sck_q;
      // bit period ends with the high phase; hold at the last bit rather than wrap
      if (sck_q && !bit_last) bit_d = bit_q + 1'b1;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      bit_q <= '0;
      sck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      bit_q <= bit_d;
      sck_q <= sck_d;
    end
  end

  assign sck      = sck_q;
  assign sample   = run && !sck_q && div_end;
  assign last_bit = run && sck_q && div_end && bit_last;

endmodule

// File: rtl/adc_serial_reader.sv
// adc_serial_reader: front end for a 16-bit SPI-style serial ADC.
//   clk, reset  - system clock, async active-high reset
//   enable      - level: back-to-back conversions
//   trigger     - pulse: one conversion (only honoured in IDLE)
//   sdo         - converter data, synchronous to clk, MSB first
//   cnv         - conversion start, high CONV_CYCLES cycles per frame
//   sck         - serial clock, idles low
//   data        - last completed word, held until the next one
//   data_ready  - one-cycle strobe with each new word
//   busy        - high whenever a frame is in progress
// All outputs are registered from the next-state value, so each output
// changes on the same edge as the state it belongs to.
module adc_serial_reader
  import adc_reader_pkg::*;
#(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int CONV_CYCLES = DEF_CONV_CYCLES,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  trigger,
  input  logic                  sdo,
  output logic                  cnv,
  output logic                  sck,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_ready,
  output logic                  busy
);

  localparam int CNT_W = cnt_w(CONV_CYCLES);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  cnv_q, cnv_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;

  logic sck_run, sample, last_bit;

  assign sck_run = (state_q == SHIFT);

  adc_sck_gen #(
    .CLK_DIV    (CLK_DIV),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sck_gen (
    .clk      (clk),
    .reset    (reset),
    .run      (sck_run),
    .sck      (sck),
    .sample   (sample),
    .last_bit (last_bit)
  );

  // state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      cnv_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      cnv_q   <= cnv_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable || trigger) state_d = CONVERT;
      CONVERT: if (cnt_q == CNT_W'(CONV_CYCLES - 1)) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = enable ? CONVERT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs and datapath
  always_comb begin
    // conversion timer only counts while staying in CONVERT
    cnt_d   = (state_q == CONVERT && state_d == CONVERT) ? cnt_q + 1'b1 : '0;
    shift_d = sample ? {shift_q[DATA_WIDTH-2:0], sdo} : shift_q;
    data_d  = (state_d == DONE) ? shift_q : data_q;
    cnv_d   = (state_d == CONVERT);
    ready_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  assign cnv        = cnv_q;
  assign data       = data_q;
  assign data_ready = ready_q;
  assign busy       = busy_q;

endmodule
